// File: rtl/dmem_arbiter_pkg.sv
// Shared widths, FSM encoding and counter helper for the two-port dmem arbiter.
package dmem_arbiter_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t sat_inc(cnt_t c, cnt_t lim);
        return (c >= lim) ? lim : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between the two dmem requesters, the arbiter and the dmem macro.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              p0_req;
    logic              p0_wren;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_wren;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;
    logic              busy;

    modport slave (
        input  p0_req, p0_wren, p0_addr, p0_wdata,
        input  p1_req, p1_wren, p1_addr, p1_wdata,
        input  mem_q,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_addr, mem_data, mem_wren, busy
    );

    modport master (
        output p0_req, p0_wren, p0_addr, p0_wdata,
        output p1_req, p1_wren, p1_addr, p1_wdata,
        output mem_q,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_addr, mem_data, mem_wren, busy
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// Grant decision: keep the current owner until its burst limit, else hand over in the same cycle.
module rr_pick
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic [1:0] state,
    input  cnt_t       cnt,
    output logic [1:0] grant
);

    localparam cnt_t LIM = cnt_t'(MAX_BURST);

    always_comb begin
        grant = 2'b00;
        case (state)
            ST_OWN0: begin
                if (req[0] && ((cnt < LIM) || !req[1])) grant = 2'b01;
                else if (req[1])                         grant = 2'b10;
            end
            ST_OWN1: begin
                if (req[1] && ((cnt < LIM) || !req[0])) grant = 2'b10;
                else if (req[0])                         grant = 2'b01;
            end
            default: begin
                // on contention from idle, favour whoever did not own the bus last
                if (req == 2'b11) grant = last_owner ? 2'b01 : 2'b10;
                else              grant = req;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port dmem arbiter: burst-limited ownership, zero-cycle handover, one-cycle read return.
//   state   | meaning
//   IDLE    | no access issued last cycle
//   OWN0    | port 0 owns the bus, cnt = grants in its current run
//   OWN1    | port 1 owns the bus, cnt = grants in its current run
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    localparam cnt_t BURST_LIM = cnt_t'(MAX_BURST);

    logic [1:0]        state;
    cnt_t              cnt;
    logic              last_owner;
    logic [1:0]        pick;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] data_mux;
    logic              wren_mux;

    rr_pick #(.MAX_BURST(MAX_BURST)) u_rr_pick (
        .req        ({bus.p1_req, bus.p0_req}),
        .last_owner (last_owner),
        .state      (state),
        .cnt        (cnt),
        .grant      (pick)
    );

    // grants are suppressed combinationally while reset is held
    assign gnt = rst_n ? pick : 2'b00;

    always_comb begin
        addr_mux = '0;
        data_mux = '0;
        wren_mux = 1'b0;
        if (gnt[0]) begin
            addr_mux = bus.p0_addr;
            data_mux = bus.p0_wdata;
            wren_mux = bus.p0_wren;
        end else if (gnt[1]) begin
            addr_mux = bus.p1_addr;
            data_mux = bus.p1_wdata;
            wren_mux = bus.p1_wren;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_owner <= 1'b1;
            rvalid     <= 2'b00;
        end else begin
            rvalid <= {gnt[1] & ~bus.p1_wren, gnt[0] & ~bus.p0_wren};
            if (gnt[0]) begin
                if (state == ST_OWN0) begin
                    cnt <= sat_inc(cnt, BURST_LIM);
                end else begin
                    state      <= ST_OWN0;
                    cnt        <= cnt_t'(1);
                    last_owner <= 1'b0;
                end
            end else if (gnt[1]) begin
                if (state == ST_OWN1) begin
                    cnt <= sat_inc(cnt, BURST_LIM);
                end else begin
                    state      <= ST_OWN1;
                    cnt        <= cnt_t'(1);
                    last_owner <= 1'b1;
                end
            end else begin
                state <= ST_IDLE;
                cnt   <= '0;
            end
        end
    end

    assign bus.p0_gnt    = gnt[0];
    assign bus.p1_gnt    = gnt[1];
    assign bus.p0_rvalid = rvalid[0];
    assign bus.p1_rvalid = rvalid[1];
    assign bus.p0_rdata  = bus.mem_q;
    assign bus.p1_rdata  = bus.mem_q;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_data  = data_mux;
    assign bus.mem_wren  = wren_mux;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural grant/memory model checked every cycle, directed cases, random traffic.
module tb_dmem_arbiter;

    localparam int MAX = 4;

    logic clk;
    logic rst_n;

    dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_BURST(MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int a);
        return (a == 16) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(a));
    endfunction

    // dmem macro: synchronous read, q valid one clock after the address
    logic [31:0] env_mem [4096];
    initial begin
        logic [11:0] ca;
        logic [31:0] cd;
        logic        cw;
        for (int i = 0; i < 4096; i++) env_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            #3;
            ca = bus.mem_addr;
            cd = bus.mem_data;
            cw = bus.mem_wren;
            @(posedge clk);
            if (cw) env_mem[ca] = cd;
            bus.mem_q <= env_mem[ca];
        end
    end

    int          n_checks = 0;
    int          n_err    = 0;
    int          m_last, m_prev, m_run;
    bit          exp_rv0, exp_rv1;
    logic [31:0] exp_rd0, exp_rd1;
    logic [31:0] shadow [4096];
    bit          rst_seen;
    int          wait0, wait1;
    logic [1:0]  s_gnt;
    logic        s_rv0, s_rv1, s_wren, s_busy;
    logic [31:0] s_rd0;
    logic [11:0] s_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare DUT against the model at the falling edge, then advance the model.
    task automatic step(input bit rst_mid);
        int          g;
        logic [1:0]  eg;
        logic [11:0] ea;
        logic [31:0] ed;
        logic        ew;
        @(negedge clk);
        if (!rst_seen) begin
            m_last = 1; m_prev = -1; m_run = 0; exp_rv0 = 0; exp_rv1 = 0;
        end
        if (!rst_n)                       g = -1;
        else if (bus.p0_req && bus.p1_req) g = (m_prev >= 0 && m_run < MAX) ? m_prev : 1 - m_last;
        else if (bus.p0_req)              g = 0;
        else if (bus.p1_req)              g = 1;
        else                              g = -1;
        eg = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
        ea = (g == 0) ? bus.p0_addr  : (g == 1) ? bus.p1_addr  : 12'h000;
        ed = (g == 0) ? bus.p0_wdata : (g == 1) ? bus.p1_wdata : 32'h0;
        ew = (g == 0) ? bus.p0_wren  : (g == 1) ? bus.p1_wren  : 1'b0;

        chk("gnt",      32'({bus.p1_gnt, bus.p0_gnt}), 32'(eg));
        chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
        chk("mem_data", bus.mem_data, ed);
        chk("mem_wren", 32'(bus.mem_wren), 32'(ew));
        chk("p0_rvalid", 32'(bus.p0_rvalid), 32'(exp_rv0));
        chk("p1_rvalid", 32'(bus.p1_rvalid), 32'(exp_rv1));
        if (exp_rv0) chk("p0_rdata", bus.p0_rdata, exp_rd0);
        if (exp_rv1) chk("p1_rdata", bus.p1_rdata, exp_rd1);
        chk("busy", 32'(bus.busy), 32'(m_prev >= 0));

        if (!rst_n || !bus.p0_req) wait0 = 0;
        else if (bus.p0_gnt) begin chk("p0_wait_bound", 32'(wait0 <= MAX), 32'd1); wait0 = 0; end
        else wait0++;
        if (!rst_n || !bus.p1_req) wait1 = 0;
        else if (bus.p1_gnt) begin chk("p1_wait_bound", 32'(wait1 <= MAX), 32'd1); wait1 = 0; end
        else wait1++;

        s_gnt  = {bus.p1_gnt, bus.p0_gnt};
        s_rv0  = bus.p0_rvalid;
        s_rv1  = bus.p1_rvalid;
        s_rd0  = bus.p0_rdata;
        s_wren = bus.mem_wren;
        s_busy = bus.busy;
        s_addr = bus.mem_addr;

        exp_rv0 = (g == 0) && !ew;
        exp_rv1 = (g == 1) && !ew;
        exp_rd0 = shadow[ea];
        exp_rd1 = shadow[ea];
        if (g >= 0 && ew) shadow[ea] = ed;
        if (g < 0)            m_run = 0;
        else if (g == m_prev) m_run++;
        else                  m_run = 1;
        if (g >= 0) m_last = g;
        m_prev = g;

        if (rst_mid) rst_n = 1'b0;
        rst_seen = rst_n;
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input bit rq, input bit wr, input logic [11:0] a, input logic [31:0] d);
        bus.p0_req = rq; bus.p0_wren = wr; bus.p0_addr = a; bus.p0_wdata = d;
    endtask

    task automatic set_p1(input bit rq, input bit wr, input logic [11:0] a, input logic [31:0] d);
        bus.p1_req = rq; bus.p1_wren = wr; bus.p1_addr = a; bus.p1_wdata = d;
    endtask

    logic [1:0] pat_alt [8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};

    initial begin
        int first;
        rst_n = 1'b0;
        rst_seen = 1'b0;
        wait0 = 0; wait1 = 0;
        for (int i = 0; i < 4096; i++) shadow[i] = init_word(i);
        set_p0(0, 0, 12'h0, 32'h0);
        set_p1(0, 0, 12'h0, 32'h0);
        @(posedge clk); #1;

        // reset holds grants off even with a request pending
        set_p0(1, 1, 12'h055, 32'hFFFF0000);
        step(0);
        chk("rst_gnt",  32'(s_gnt),  32'd0);
        chk("rst_wren", 32'(s_wren), 32'd0);
        chk("rst_busy", 32'(s_busy), 32'd0);
        set_p0(0, 0, 12'h0, 32'h0);
        step(0);
        rst_n = 1'b1;
        step(0);

        // lone p0 read of a preloaded word
        set_p0(1, 0, 12'h010, 32'h0);
        step(0);
        chk("d1_gnt",  32'(s_gnt),  32'h1);
        chk("d1_addr", 32'(s_addr), 32'h010);
        set_p0(0, 0, 12'h0, 32'h0);
        step(0);
        chk("d1_rvalid", 32'(s_rv0), 32'd1);
        chk("d1_rdata",  s_rd0, 32'hDEADBEEF);
        chk("d1_p1_rv",  32'(s_rv1), 32'd0);
        chk("d1_gnt_off", 32'(s_gnt), 32'd0);

        // p1 write followed by p0 read-back
        set_p1(1, 1, 12'h0A5, 32'h12345678);
        step(0);
        chk("d2_wgnt",  32'(s_gnt),  32'h2);
        chk("d2_wren",  32'(s_wren), 32'd1);
        set_p1(0, 0, 12'h0, 32'h0);
        set_p0(1, 0, 12'h0A5, 32'h0);
        step(0);
        chk("d2_rgnt",  32'(s_gnt),  32'h1);
        chk("d2_wren0", 32'(s_wren), 32'd0);
        chk("d2_no_p1_rv", 32'(s_rv1), 32'd0);
        set_p0(0, 0, 12'h0, 32'h0);
        step(0);
        chk("d2_rvalid", 32'(s_rv0), 32'd1);
        chk("d2_rdata",  s_rd0, 32'h12345678);
        chk("d2_p1_rv",  32'(s_rv1), 32'd0);

        // both requesting out of reset: 4+4 alternation, no gap
        rst_n = 1'b0;
        step(0);
        step(0);
        set_p0(1, 0, 12'h100, 32'h0);
        set_p1(1, 0, 12'h200, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(0);
            chk("d3_alt_gnt", 32'(s_gnt), 32'(pat_alt[i]));
        end
        set_p0(0, 0, 12'h0, 32'h0);
        set_p1(0, 0, 12'h0, 32'h0);
        step(0);
        step(0);

        // sole requester is never forced off
        set_p0(1, 0, 12'h020, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step(0);
            chk("d4_sole_gnt", 32'(s_gnt), 32'h1);
        end
        set_p0(0, 0, 12'h0, 32'h0);
        step(0);

        // p1 joins at cycle 6 of a p0 run
        first = 0;
        set_p0(1, 0, 12'h021, 32'h0);
        for (int c = 1; c <= 10; c++) begin
            if (c == 6) set_p1(1, 0, 12'h022, 32'h0);
            step(0);
            if (s_gnt == 2'b10 && first == 0) begin
                first = c;
                set_p1(0, 0, 12'h0, 32'h0);
            end
        end
        chk("d4_p1_by_9", 32'(first >= 6 && first <= 9), 32'd1);
        set_p0(0, 0, 12'h0, 32'h0);
        set_p1(0, 0, 12'h0, 32'h0);
        step(0);

        // reset asserted right after a p1 read grant
        set_p1(1, 0, 12'h033, 32'h0);
        step(1);
        chk("d5_gnt", 32'(s_gnt), 32'h2);
        set_p1(0, 0, 12'h0, 32'h0);
        step(0);
        chk("d5_rv1",  32'(s_rv1),  32'd0);
        chk("d5_busy", 32'(s_busy), 32'd0);
        set_p0(1, 0, 12'h040, 32'h0);
        set_p1(1, 0, 12'h041, 32'h0);
        rst_n = 1'b1;
        step(0);
        chk("d5_post_rst_gnt", 32'(s_gnt), 32'h1);
        set_p0(0, 0, 12'h0, 32'h0);
        set_p1(0, 0, 12'h0, 32'h0);
        step(0);
        step(0);

        // random traffic; a requester holds its payload until granted
        s_gnt = 2'b00;
        for (int n = 0; n < 10000; n++) begin
            if (!bus.p0_req || s_gnt[0])
                set_p0($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 40,
                       12'($urandom_range(0, 31)), $urandom);
            if (!bus.p1_req || s_gnt[1])
                set_p1($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 40,
                       12'($urandom_range(0, 31)), $urandom);
            step(0);
        end
        set_p0(0, 0, 12'h0, 32'h0);
        set_p1(0, 0, 12'h0, 32'h0);
        step(0);
        step(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
